regbank_sched: RTL and testbench

Two-port scheduler for the 8-entry 1-bit XOR register bank (`REG1B8SZ`). Two requesters, A and B, share the bank. Each requester issues either a point update or a range-XOR query. The block arbitrates round-robin, turns each command into one bank operation per cycle, and builds a range result `[lo,hi]` from two prefix queries. It sits between the command-issuing logic and the bank, and is the only driver of the bank's `inst`/`idx`/`xorval` inputs.

---
 rtl/regbank_sched_if.sv | 37 +++
 rtl/regbank_sched.sv | 150 +++++++++++++++
 tb/tb_regbank_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_sched_if.sv
// Requester-side bundle for regbank_sched: two command ports (A, B)
// and their one-cycle response pulses sharing a single data line.
interface regbank_sched_if;
    logic       a_valid;
    logic       a_ready;
    logic       a_op;
    logic [2:0] a_lo;
    logic [2:0] a_hi;
    logic       a_val;
    logic       a_rsp_valid;

    logic       b_valid;
    logic       b_ready;
    logic       b_op;
    logic [2:0] b_lo;
    logic [2:0] b_hi;
    logic       b_val;
    logic       b_rsp_valid;

    logic       rsp_data;

    modport master (
        output a_valid, a_op, a_lo, a_hi, a_val,
        output b_valid, b_op, b_lo, b_hi, b_val,
        input  a_ready, a_rsp_valid,
        input  b_ready, b_rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  a_valid, a_op, a_lo, a_hi, a_val,
        input  b_valid, b_op, b_lo, b_hi, b_val,
        output a_ready, a_rsp_valid,
        output b_ready, b_rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/regbank_sched.sv
// Round-robin two-port scheduler for the 8-entry 1-bit XOR bank.
// Range queries are built from two prefix queries: P(hi) ^ P(lo-1).
module regbank_sched (
    input  logic           clk,
    input  logic           reset,
    regbank_sched_if.slave req,
    output logic           busy,
    output logic [1:0]     bank_inst,
    output logic [2:0]     bank_idx,
    output logic           bank_xorval,
    input  logic           bank_rangexor
);

    typedef enum logic [2:0] {
        IDLE,
        UPD,
        QHI,
        QLO,
        RSP
    } state_t;

    state_t     state;
    state_t     state_n;

    logic       prio;
    logic       own_q;
    logic       val_q;
    logic       acc;
    logic [2:0] lo_q;
    logic [2:0] hi_q;

    logic       gnt_a;
    logic       gnt_b;
    logic       take;
    logic       sel_op;
    logic       sel_val;
    logic [2:0] sel_lo;
    logic [2:0] sel_hi;
    logic [2:0] min_b;
    logic [2:0] max_b;

    logic       a_rsp;
    logic       b_rsp;
    logic       rsp_d;

    // prio: 0 = A wins a tie, 1 = B wins a tie
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state == IDLE) begin
            gnt_a = req.a_valid & (~req.b_valid | ~prio);
            gnt_b = req.b_valid & (~req.a_valid | prio);
        end
    end

    assign take = gnt_a | gnt_b;

    always_comb begin
        sel_op  = req.a_op;
        sel_val = req.a_val;
        sel_lo  = req.a_lo;
        sel_hi  = req.a_hi;
        if (gnt_b) begin
            sel_op  = req.b_op;
            sel_val = req.b_val;
            sel_lo  = req.b_lo;
            sel_hi  = req.b_hi;
        end
    end

    // Swapped bounds are legal, so normalise before latching.
    assign min_b = (sel_lo < sel_hi) ? sel_lo : sel_hi;
    assign max_b = (sel_lo < sel_hi) ? sel_hi : sel_lo;

    always_comb begin
        state_n     = state;
        bank_inst   = 2'b11;
        bank_idx    = 3'd0;
        bank_xorval = 1'b0;
        a_rsp       = 1'b0;
        b_rsp       = 1'b0;
        rsp_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_n = sel_op ? QHI : UPD;
                end
            end
            UPD: begin
                bank_inst   = 2'b00;
                bank_idx    = lo_q;
                bank_xorval = val_q;
                state_n     = IDLE;
            end
            QHI: begin
                bank_inst = 2'b01;
                bank_idx  = hi_q;
                state_n   = (lo_q == 3'd0) ? RSP : QLO;
            end
            QLO: begin
                bank_inst = 2'b01;
                bank_idx  = lo_q - 3'd1;
                state_n   = RSP;
            end
            RSP: begin
                a_rsp   = ~own_q;
                b_rsp   = own_q;
                rsp_d   = acc;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
            acc   <= 1'b0;
            own_q <= 1'b0;
            val_q <= 1'b0;
            lo_q  <= 3'd0;
            hi_q  <= 3'd0;
        end else begin
            state <= state_n;
            if (take) begin
                prio  <= gnt_a;
                own_q <= gnt_b;
                val_q <= sel_val;
                lo_q  <= min_b;
                hi_q  <= max_b;
            end
            if (state == QHI) begin
                acc <= bank_rangexor;
            end else if (state == QLO) begin
                acc <= acc ^ bank_rangexor;
            end
        end
    end

    assign req.a_ready     = gnt_a;
    assign req.b_ready     = gnt_b;
    assign req.a_rsp_valid = a_rsp;
    assign req.b_rsp_valid = b_rsp;
    assign req.rsp_data    = rsp_d;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_regbank_sched.sv
// Directed bench for regbank_sched with a behavioural model of the
// 8-entry XOR bank; expected values are hand-computed constants.
module tb_regbank_sched;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [1:0] bank_inst;
    logic [2:0] bank_idx;
    logic       bank_xorval;
    logic       bank_rangexor;

    logic [7:0] bits;
    int         n_cmp;
    int         n_bad;

    regbank_sched_if rif ();

    regbank_sched dut (
        .clk           (clk),
        .reset         (reset),
        .req           (rif.slave),
        .busy          (busy),
        .bank_inst     (bank_inst),
        .bank_idx      (bank_idx),
        .bank_xorval   (bank_xorval),
        .bank_rangexor (bank_rangexor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bits <= 8'h00;
        end else if (bank_inst == 2'b00) begin
            bits[bank_idx] <= bits[bank_idx] ^ bank_xorval;
        end
    end

    always_comb begin
        bank_rangexor = 1'b0;
        if (bank_inst == 2'b01) begin
            for (int i = 0; i < 8; i++) begin
                if (i <= int'(bank_idx)) begin
                    bank_rangexor = bank_rangexor ^ bits[i];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit who, input bit en, input bit op,
                         input logic [2:0] lo, input logic [2:0] hi,
                         input bit val);
        if (who) begin
            rif.b_valid = en;
            rif.b_op    = op;
            rif.b_lo    = lo;
            rif.b_hi    = hi;
            rif.b_val   = val;
        end else begin
            rif.a_valid = en;
            rif.a_op    = op;
            rif.a_lo    = lo;
            rif.a_hi    = hi;
            rif.a_val   = val;
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input bit who, input bit op, input logic [2:0] lo,
                        input logic [2:0] hi, input bit val);
        drive(who, 1'b1, op, lo, hi, val);
        @(negedge clk);
        check("send_ready", who ? rif.b_ready : rif.a_ready, 8'd1);
        check("idle_inst", bank_inst, 8'd3);
        tick();
        drive(who, 1'b0, op, lo, hi, val);
    endtask

    task automatic upd(input bit who, input logic [2:0] idx, input bit val);
        send(who, 1'b0, idx, 3'd7, val);
        @(negedge clk);
        check("upd_inst", bank_inst, 8'd0);
        check("upd_idx", bank_idx, idx);
        check("upd_xorval", bank_xorval, val);
        check("upd_ready", rif.a_ready | rif.b_ready, 8'd0);
        tick();
    endtask

    task automatic query(input bit who, input logic [2:0] lo,
                         input logic [2:0] hi, input bit exp_data);
        logic [2:0] mn;
        logic [2:0] mx;
        int         lat;
        int         got;
        mn  = (lo < hi) ? lo : hi;
        mx  = (lo < hi) ? hi : lo;
        lat = (mn == 3'd0) ? 2 : 3;
        got = 0;
        send(who, 1'b1, lo, hi, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("qhi_inst", bank_inst, 8'd1);
                check("qhi_idx", bank_idx, mx);
            end
            if (k == 2 && lat == 3) begin
                check("qlo_inst", bank_inst, 8'd1);
                check("qlo_idx", bank_idx, mn - 3'd1);
            end
            if (rif.a_rsp_valid || rif.b_rsp_valid) begin
                got = k;
                check("rsp_a", rif.a_rsp_valid, !who);
                check("rsp_b", rif.b_rsp_valid, who);
                check("rsp_data", rif.rsp_data, exp_data);
                tick();
                break;
            end
            tick();
        end
        check("rsp_latency", got[7:0], lat[7:0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

        do_reset();
        @(negedge clk);
        check("rst_a_ready", rif.a_ready, 8'd0);
        check("rst_b_ready", rif.b_ready, 8'd0);
        check("rst_a_rsp", rif.a_rsp_valid, 8'd0);
        check("rst_b_rsp", rif.b_rsp_valid, 8'd0);
        check("rst_rsp_data", rif.rsp_data, 8'd0);
        check("rst_busy", busy, 8'd0);
        check("rst_inst", bank_inst, 8'd3);
        check("rst_idx", bank_idx, 8'd0);
        check("rst_xorval", bank_xorval, 8'd0);
        tick();

        // bits = {3}
        upd(1'b0, 3'd3, 1'b1);
        query(1'b0, 3'd2, 3'd5, 1'b1);
        query(1'b0, 3'd4, 3'd7, 1'b0);

        // bits = {0,1,6}
        do_reset();
        upd(1'b1, 3'd0, 1'b1);
        upd(1'b1, 3'd1, 1'b1);
        upd(1'b1, 3'd6, 1'b1);
        query(1'b1, 3'd0, 3'd6, 1'b1);
        query(1'b1, 3'd6, 3'd1, 1'b0);
        query(1'b1, 3'd1, 3'd6, 1'b0);
        query(1'b1, 3'd6, 3'd2, 1'b1);

        // abort a query in QLO; bank {0,1,6} is cleared by reset
        send(1'b0, 1'b1, 3'd2, 3'd7, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 8'd0);
        check("abort_inst", bank_inst, 8'd3);
        check("abort_rsp", rif.a_rsp_valid, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", rif.a_rsp_valid | rif.b_rsp_valid, 8'd0);
            tick();
        end
        query(1'b0, 3'd0, 3'd7, 1'b0);

        // both held valid: A updates idx 2, B queries [0,7]
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 3'd0, 3'd7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tie_a_ready", rif.a_ready, (i % 2 == 0) ? 8'd1 : 8'd0);
            check("tie_b_ready", rif.b_ready, (i % 2 == 1) ? 8'd1 : 8'd0);
            tick();
            @(negedge clk);
            check("tie_busy_ready", rif.a_ready | rif.b_ready, 8'd0);
            if (i % 2 == 0) begin
                check("tie_upd_inst", bank_inst, 8'd0);
                tick();
            end else begin
                check("tie_qhi_inst", bank_inst, 8'd1);
                tick();
                @(negedge clk);
                check("tie_rsp_ready", rif.a_ready | rif.b_ready, 8'd0);
                check("tie_rsp_a", rif.a_rsp_valid, 8'd0);
                check("tie_rsp_b", rif.b_rsp_valid, 8'd1);
                check("tie_rsp_data", rif.rsp_data, (i == 1) ? 8'd1 : 8'd0);
                tick();
            end
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

        // back-to-back updates to idx 5 cancel out
        do_reset();
        upd(1'b0, 3'd5, 1'b1);
        upd(1'b1, 3'd5, 1'b1);
        upd(1'b0, 3'd5, 1'b1);
        upd(1'b1, 3'd5, 1'b1);
        query(1'b0, 3'd5, 3'd5, 1'b0);
        upd(1'b1, 3'd5, 1'b1);
        query(1'b0, 3'd4, 3'd5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
